// File: rtl/somador_serial_4bits.sv
// Bit-serial two's-complement adder: S = A + B + Cin, LSB first, one bit per clock.
// Result, carry-out and signed overflow are registered and held until the next operation.
module somador_serial_4bits #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit;
  logic             carry_nxt;

  assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is still the carry into the MSB at this edge
          s_d     = {sum_bit, acc_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_somador_serial_4bits.sv
// Self-checking bench for somador_serial_4bits: directed vectors, corner sequences and
// randomized operations compared against an arithmetic reference model.
module tb_somador_serial_4bits;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] s;
  logic         cout, overflow;

  int checks = 0;
  int errors = 0;

  somador_serial_4bits #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sums, unsigned for s/cout and signed range test for overflow.
  function automatic vec_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    vec_t r;
    int usum, sa, sb, ssum;
    usum = int'(ta) + int'(tb) + int'(tc);
    sa   = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb   = tb[W-1] ? int'(tb) - (1 << W) : int'(tb);
    ssum = sa + sb + int'(tc);
    r.a = ta; r.b = tb; r.cin = tc;
    r.s    = W'(usum % (1 << W));
    r.cout = (usum >= (1 << W));
    r.ovf  = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
    return r;
  endfunction

  // One full operation: pulse start, measure latency/busy, compare result, then check hold.
  task automatic run_op(input vec_t v);
    int n, busy_cnt;
    logic [W-1:0] s_hold;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;
    n = 0; busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    chk("latency", n, W);
    if (busy) busy_cnt++;
    chk("s", int'(s), int'(v.s));
    chk("cout", int'(cout), int'(v.cout));
    chk("overflow", int'(overflow), int'(v.ovf));
    @(negedge clk);
    chk("busy_cycles", busy_cnt, W + 1);
    chk("done_width", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    s_hold = s;
    chk("s_hold", int'(s_hold), int'(v.s));
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int dq[$];
    int npulse;
    vecs[0] = '{a: 4'd5,  b: 4'd3, cin: 1'b0, s: 4'd8, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd1, cin: 1'b0, s: 4'd0, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 4'd9,  b: 4'd6, cin: 1'b1, s: 4'd0, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'd7,  b: 4'd1, cin: 1'b0, s: 4'd8, cout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 4'd8,  b: 4'd8, cin: 1'b0, s: 4'd0, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 4'd2,  b: 4'd2, cin: 1'b0, s: 4'd4, cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, cout: 1'b1, ovf: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // start re-asserted during SHIFT with new operands must be ignored
    @(negedge clk);
    a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 4'd15; b = 4'd15; start = 1'b1;
      if (done) npulse++;
    end
    @(negedge clk);
    start = 1'b0;
    if (done) begin
      npulse++;
      chk("ign_s", int'(s), 4);
      chk("ign_cout", int'(cout), 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("ign_pulses", npulse, 1);

    // asynchronous reset during the second SHIFT cycle aborts the operation
    @(negedge clk);
    a = 4'd6; b = 4'd5; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_s", int'(s), 0);
    chk("abort_cout", int'(cout), 0);
    chk("abort_ovf", int'(overflow), 0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    rst_n = 1'b1;
    chk("abort_pulses", npulse, 0);
    v = '{a: 4'd3, b: 4'd4, cin: 1'b0, s: 4'd7, cout: 1'b0, ovf: 1'b0};
    run_op(v);

    // start held continuously: one result every W+2 cycles
    @(negedge clk);
    a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (done) begin
        dq.push_back(i);
        chk("b2b_s", int'(s), 2);
      end
      if (dq.size() > 0) chk("b2b_stable", int'(s), 2);
    end
    start = 1'b0;
    chk("b2b_pulses", dq.size(), 4);
    for (int i = 1; i < dq.size(); i++) chk("b2b_spacing", dq[i] - dq[i-1], W + 2);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      v = model(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      run_op(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
